// File: rtl/vdma_burst_arbiter.sv
// vdma_burst_arbiter: shares one AXI-master command port between NUM_CH VDMA channels.
// One transaction in flight at a time, granted round-robin, with a WAIT_DONE watchdog.
// Optional build macro TAIL_PRIORITY_EN: when any tail request is pending, arbitration
// considers tail requesters only, so line/frame tails flush ahead of bursts.
`timescale 1ns/1ps
module vdma_burst_arbiter #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned IDW         = 2,
    parameter int unsigned LSIZE       = 9,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       ch_burst_req,
    input  logic [NUM_CH-1:0]       ch_tail_req,
    input  logic [NUM_CH*LSIZE-1:0] ch_len,
    output logic [NUM_CH-1:0]       ch_resp,
    output logic [NUM_CH-1:0]       ch_done,
    output logic                    m_cmd_valid,
    input  logic                    m_cmd_ready,
    output logic [LSIZE-1:0]        m_cmd_len,
    output logic [IDW-1:0]          m_cmd_id,
    output logic                    m_cmd_tail,
    input  logic                    m_done,
    output logic                    busy,
    output logic                    timeout_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       m_cmd_id_q, m_cmd_id_d;
    logic [LSIZE-1:0]     m_cmd_len_q, m_cmd_len_d;
    logic                 m_cmd_tail_q, m_cmd_tail_d;
    logic                 m_cmd_valid_q, m_cmd_valid_d;
    logic [NUM_CH-1:0]    ch_resp_q, ch_resp_d;
    logic [NUM_CH-1:0]    ch_done_q, ch_done_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [WD_W-1:0]      wd_q, wd_d;

    logic [NUM_CH-1:0]    cand;
    logic                 win_found;
    logic [IDW-1:0]       win_id;
    logic                 win_tail;
    logic [LSIZE-1:0]     win_len;
    logic [NUM_CH-1:0]    id_onehot;

    // Round-robin winner search: first candidate strictly after the last grant, wrapping.
    always_comb begin
        int unsigned idx;
`ifdef TAIL_PRIORITY_EN
        cand = (|ch_tail_req) ? ch_tail_req : (ch_burst_req | ch_tail_req);
`else
        cand = ch_burst_req | ch_tail_req;
`endif
        idx       = 0;
        win_found = 1'b0;
        win_id    = '0;
        win_tail  = 1'b0;
        win_len   = '0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            idx = 32'(ptr_q) + off;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!win_found && cand[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
                win_tail  = ch_tail_req[idx];
                win_len   = ch_len[idx*LSIZE +: LSIZE];
            end
        end
    end

    // One-hot of the granted channel, used for the resp/done pulses.
    always_comb begin
        id_onehot = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            id_onehot[i] = (m_cmd_id_q == IDW'(i));
        end
    end

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        m_cmd_id_d    = m_cmd_id_q;
        m_cmd_len_d   = m_cmd_len_q;
        m_cmd_tail_d  = m_cmd_tail_q;
        m_cmd_valid_d = m_cmd_valid_q;
        wd_d          = wd_q;
        ch_resp_d     = '0;
        ch_done_d     = '0;
        timeout_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d       = S_CMD;
                    ptr_d         = win_id;
                    m_cmd_id_d    = win_id;
                    m_cmd_len_d   = win_len;
                    m_cmd_tail_d  = win_tail;
                    m_cmd_valid_d = 1'b1;
                end
            end
            S_CMD: begin
                // m_done before the handshake belongs to nobody and is dropped.
                if (m_cmd_ready) begin
                    m_cmd_valid_d = 1'b0;
                    ch_resp_d     = id_onehot;
                    wd_d          = '0;
                    if (m_done) begin
                        state_d   = S_DONE;
                        ch_done_d = id_onehot;
                    end else begin
                        state_d   = S_WAIT_DONE;
                    end
                end
            end
            S_WAIT_DONE: begin
                if (m_done) begin
                    state_d   = S_DONE;
                    ch_done_d = id_onehot;
                end else if ((TIMEOUT_CYC != 0) && (wd_q == WD_LAST)) begin
                    state_d       = S_DONE;
                    ch_done_d     = id_onehot;
                    timeout_err_d = 1'b1;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset returns to idle with channel 0 next in line.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            ptr_q         <= IDW'(NUM_CH - 1);
            m_cmd_id_q    <= '0;
            m_cmd_len_q   <= '0;
            m_cmd_tail_q  <= 1'b0;
            m_cmd_valid_q <= 1'b0;
            ch_resp_q     <= '0;
            ch_done_q     <= '0;
            timeout_err_q <= 1'b0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            m_cmd_id_q    <= m_cmd_id_d;
            m_cmd_len_q   <= m_cmd_len_d;
            m_cmd_tail_q  <= m_cmd_tail_d;
            m_cmd_valid_q <= m_cmd_valid_d;
            ch_resp_q     <= ch_resp_d;
            ch_done_q     <= ch_done_d;
            timeout_err_q <= timeout_err_d;
            wd_q          <= wd_d;
        end
    end

    assign ch_resp     = ch_resp_q;
    assign ch_done     = ch_done_q;
    assign m_cmd_valid = m_cmd_valid_q;
    assign m_cmd_len   = m_cmd_len_q;
    assign m_cmd_id    = m_cmd_id_q;
    assign m_cmd_tail  = m_cmd_tail_q;
    assign timeout_err = timeout_err_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_vdma_burst_arbiter.sv
// Bench for vdma_burst_arbiter: directed scenarios with literal expectations, then
// randomized channel/downstream traffic checked every cycle against a transaction model.
`timescale 1ns/1ps
module tb_vdma_burst_arbiter;

    localparam int NUM_CH = 4;
    localparam int IDW    = 2;
    localparam int LSIZE  = 9;
    localparam int TO     = 16;

    logic                    clock = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_CH-1:0]       ch_burst_req = '0;
    logic [NUM_CH-1:0]       ch_tail_req = '0;
    logic [NUM_CH*LSIZE-1:0] ch_len = '0;
    logic [NUM_CH-1:0]       ch_resp;
    logic [NUM_CH-1:0]       ch_done;
    logic                    m_cmd_valid;
    logic                    m_cmd_ready = 1'b0;
    logic [LSIZE-1:0]        m_cmd_len;
    logic [IDW-1:0]          m_cmd_id;
    logic                    m_cmd_tail;
    logic                    m_done = 1'b0;
    logic                    busy;
    logic                    timeout_err;

    int total = 0;
    int bad   = 0;

    vdma_burst_arbiter #(
        .NUM_CH(NUM_CH),
        .IDW(IDW),
        .LSIZE(LSIZE),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .ch_burst_req(ch_burst_req),
        .ch_tail_req(ch_tail_req),
        .ch_len(ch_len),
        .ch_resp(ch_resp),
        .ch_done(ch_done),
        .m_cmd_valid(m_cmd_valid),
        .m_cmd_ready(m_cmd_ready),
        .m_cmd_len(m_cmd_len),
        .m_cmd_id(m_cmd_id),
        .m_cmd_tail(m_cmd_tail),
        .m_done(m_done),
        .busy(busy),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_len(input int ch, input int v);
        ch_len[ch*LSIZE +: LSIZE] = LSIZE'(v);
    endtask

    // ---------------- transaction-level reference model ----------------
    int  m_ptr = NUM_CH - 1;
    bit  have_txn = 0, accepted = 0, cooldown = 0;
    int  txn_id = 0, txn_len = 0, wait_cyc = 0;
    bit  txn_tail = 0;
    logic [NUM_CH-1:0] e_resp = '0, e_done = '0;
    bit  e_terr = 0;

    // Winner = requester with the smallest forward distance past the last grant.
    function automatic int pick(input logic [NUM_CH-1:0] c, input int ptr);
        int best, bestd, d;
        best  = -1;
        bestd = NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
            if (c[i]) begin
                d = (i + NUM_CH - ptr - 1) % NUM_CH;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic finish_txn(input bit by_timeout);
        e_done[txn_id] = 1'b1;
        e_terr         = by_timeout;
        have_txn       = 0;
        cooldown       = 1;
    endtask

    initial begin
        logic [NUM_CH-1:0] c;
        int w;
        forever begin
            @(posedge clock or negedge rst_n);
            if (!rst_n) begin
                m_ptr = NUM_CH - 1; have_txn = 0; accepted = 0; cooldown = 0;
                e_resp = '0; e_done = '0; e_terr = 0;
            end else begin
                e_resp = '0; e_done = '0; e_terr = 0;
                if (cooldown) begin
                    cooldown = 0;
                end else if (!have_txn) begin
                    c = ch_burst_req | ch_tail_req;
`ifdef TAIL_PRIORITY_EN
                    if (|ch_tail_req) c = ch_tail_req;
`endif
                    w = pick(c, m_ptr);
                    if (w >= 0) begin
                        have_txn = 1; accepted = 0; txn_id = w; m_ptr = w;
                        txn_len  = int'(ch_len[w*LSIZE +: LSIZE]);
                        txn_tail = ch_tail_req[w];
                    end
                end else if (!accepted) begin
                    if (m_cmd_ready) begin
                        accepted = 1; e_resp[txn_id] = 1'b1; wait_cyc = 0;
                        if (m_done) finish_txn(0);
                    end
                end else begin
                    if (m_done) finish_txn(0);
                    else if (wait_cyc == TO - 1) finish_txn(1);
                    else wait_cyc++;
                end
            end
        end
    end

    // Compare process: every out-of-reset cycle, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (rst_n) begin
                chk("m_busy", int'(busy), int'(have_txn || cooldown));
                chk("m_valid", int'(m_cmd_valid), int'(have_txn && !accepted));
                chk("m_resp", int'(ch_resp), int'(e_resp));
                chk("m_done", int'(ch_done), int'(e_done));
                chk("m_terr", int'(timeout_err), int'(e_terr));
                if (have_txn && !accepted) begin
                    chk("m_id", int'(m_cmd_id), txn_id);
                    chk("m_len", int'(m_cmd_len), txn_len);
                    chk("m_tail", int'(m_cmd_tail), int'(txn_tail));
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        ch_burst_req = '0; ch_tail_req = '0; ch_len = '0;
        m_cmd_ready = 1'b0; m_done = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int grants[6];
        int exp_order[6];
        int ng, gap, gapmin, gapmax, k, maxw;
        bit prev_valid;
        bit pend[NUM_CH];
        int waitc[NUM_CH];

        // Reset state
        repeat (3) tick();
        chk("rst_valid", int'(m_cmd_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_resp", int'(ch_resp), 0);
        chk("rst_done", int'(ch_done), 0);
        chk("rst_terr", int'(timeout_err), 0);

        // ch0 burst len=100, ready=1, m_done 5 cycles after accept
        rst_n = 1'b1;
        tick();
        set_len(0, 100); ch_burst_req = 4'b0001; m_cmd_ready = 1'b1;
        tick();
        chk("s1_valid", int'(m_cmd_valid), 1);
        chk("s1_id", int'(m_cmd_id), 0);
        chk("s1_len", int'(m_cmd_len), 100);
        chk("s1_tail", int'(m_cmd_tail), 0);
        tick();
        chk("s1_resp", int'(ch_resp), 1);
        ch_burst_req = '0;
        repeat (4) tick();
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("s1_done", int'(ch_done), 1);
        tick();
        chk("s1_done_once", int'(ch_done), 0);
        chk("s1_idle", int'(busy), 0);

        // All channels requesting continuously, immediate completion
        do_reset();
        ch_burst_req = 4'b1111; m_cmd_ready = 1'b1; m_done = 1'b1;
        exp_order = '{0, 1, 2, 3, 0, 1};
        ng = 0; gap = 0; gapmin = 99; gapmax = 0; prev_valid = 0;
        for (int c = 0; c < 60 && ng < 6; c++) begin
            tick();
            if (!busy) gap++;
            else if (gap > 0) begin
                if (gap < gapmin) gapmin = gap;
                if (gap > gapmax) gapmax = gap;
                gap = 0;
            end
            if (m_cmd_valid && !prev_valid) begin
                grants[ng] = int'(m_cmd_id);
                ng++;
            end
            prev_valid = m_cmd_valid;
        end
        chk("s2_grant_count", ng, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < ng) chk("s2_order", grants[i], exp_order[i]);
        end
        chk("s2_gap_min", gapmin, 1);
        chk("s2_gap_max", gapmax, 1);

        // ch1 tail len=37, ready low for 10 cycles
        do_reset();
        set_len(1, 37); ch_tail_req = 4'b0010;
        tick();
        chk("s3_valid", int'(m_cmd_valid), 1);
        chk("s3_id", int'(m_cmd_id), 1);
        chk("s3_len", int'(m_cmd_len), 37);
        chk("s3_tail", int'(m_cmd_tail), 1);
        set_len(1, 200);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("s3_hold_valid", int'(m_cmd_valid), 1);
            chk("s3_hold_len", int'(m_cmd_len), 37);
            chk("s3_hold_id", int'(m_cmd_id), 1);
        end
        m_cmd_ready = 1'b1;
        tick();
        chk("s3_resp", int'(ch_resp), 2);
        chk("s3_valid_drop", int'(m_cmd_valid), 0);
        ch_tail_req = '0; m_cmd_ready = 1'b0; m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("s3_done", int'(ch_done), 2);
        tick();

        // Watchdog: m_done never arrives
        do_reset();
        set_len(2, 7); ch_burst_req = 4'b0100; m_cmd_ready = 1'b1;
        tick();
        chk("s4_id", int'(m_cmd_id), 2);
        tick();
        chk("s4_resp", int'(ch_resp), 4);
        ch_burst_req = 4'b1000;
        repeat (15) tick();
        chk("s4_no_early_terr", int'(timeout_err), 0);
        chk("s4_no_early_done", int'(ch_done), 0);
        tick();
        chk("s4_terr", int'(timeout_err), 1);
        chk("s4_done", int'(ch_done), 4);
        tick();
        chk("s4_terr_once", int'(timeout_err), 0);
        chk("s4_idle", int'(busy), 0);
        tick();
        chk("s4_next_valid", int'(m_cmd_valid), 1);
        chk("s4_next_id", int'(m_cmd_id), 3);
        tick();
        ch_burst_req = '0; m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();

        // ptr=0, ch1 burst and ch3 tail pending together
        do_reset();
        ch_burst_req = 4'b0001; m_cmd_ready = 1'b1;
        tick();
        tick();
        ch_burst_req = '0; m_done = 1'b1;
        tick();
        m_done = 1'b0;
        tick();
        ch_burst_req = 4'b0010; ch_tail_req = 4'b1000;
        tick();
`ifdef TAIL_PRIORITY_EN
        chk("s5_id", int'(m_cmd_id), 3);
        chk("s5_tail", int'(m_cmd_tail), 1);
`else
        chk("s5_id", int'(m_cmd_id), 1);
        chk("s5_tail", int'(m_cmd_tail), 0);
`endif

        // Reset while waiting for m_done
        do_reset();
        ch_burst_req = 4'b0100; m_cmd_ready = 1'b1;
        tick();
        tick();
        ch_burst_req = '0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("s6_rst_busy", int'(busy), 0);
        chk("s6_rst_valid", int'(m_cmd_valid), 0);
        chk("s6_rst_resp", int'(ch_resp), 0);
        chk("s6_rst_terr", int'(timeout_err), 0);
        tick();
        rst_n = 1'b1; m_done = 1'b1;
        tick();
        m_done = 1'b0;
        chk("s6_no_done", int'(ch_done), 0);
        chk("s6_idle", int'(busy), 0);
        ch_burst_req = 4'b0101;
        tick();
        chk("s6_next_valid", int'(m_cmd_valid), 1);
        chk("s6_next_id", int'(m_cmd_id), 0);

        // Randomized traffic
        do_reset();
        maxw = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            pend[i] = 0;
            waitc[i] = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (pend[i] && ch_resp[i]) begin
                    pend[i] = 0; waitc[i] = 0;
                    ch_burst_req[i] = 1'b0; ch_tail_req[i] = 1'b0;
                end
                if (!pend[i] && $urandom_range(3) == 0) begin
                    k = int'($urandom_range(1, 3));
                    ch_burst_req[i] = k[0]; ch_tail_req[i] = k[1];
                    set_len(i, int'($urandom_range(511)));
                    pend[i] = 1;
                end else if (pend[i] && $urandom_range(15) == 0) begin
                    set_len(i, int'($urandom_range(511)));
                end
                if (pend[i]) begin
                    waitc[i]++;
                    if (waitc[i] > maxw) maxw = waitc[i];
                end
            end
            m_cmd_ready = ($urandom_range(2) != 0);
            m_done      = ($urandom_range(5) == 0);
            if (cyc == 1500) rst_n = 1'b0;
            if (cyc == 1502) rst_n = 1'b1;
            tick();
        end
        chk("rand_no_starve", int'(maxw <= 500), 1);
        ch_burst_req = '0; ch_tail_req = '0; m_cmd_ready = 1'b1; m_done = 1'b1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
